fp_mult_core: RTL and testbench
===============================

FP_MULT_CORE -- requirements
Module: fp_mult_core

Interface
REQ-001 SHALL have parameter FAST_SPECIAL, default 1: when 1, zero, Inf and NaN operands bypass the iterative multiply.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: operand pair present.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-006 SHALL have ports a and b, input, 32 each: IEEE-754 single-precision operands.
REQ-007 SHALL have port out_valid, output, 1: result fields are valid.
REQ-008 SHALL have port out_ready, input, 1: the downstream rounding stage accepts the result.
REQ-009 SHALL have port sign, output, 1: product sign.
REQ-010 SHALL have port exp, output, 10: signed pre-round biased exponent.
REQ-011 SHALL have port mantissa, output, 24: normalized significand including the hidden bit.
REQ-012 SHALL have ports guard and sticky, output, 1 each: rounding bits for the rounding stage.
REQ-013 SHALL have ports is_zero, is_inf and is_nan, output, 1 each: special-case flags.

Function
REQ-014 SHALL implement an FSM with states IDLE, MULT, NORM and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-016 On an in_valid&&in_ready edge, the block SHALL latch sign=a[31]^b[31], the exponents, and the significands {|e,frac}.
REQ-017 Operands with exp==0 (zero and denormal) SHALL be treated as zero.
REQ-018 Special-case priority SHALL be NaN > Inf > zero: NaN if either operand is NaN or the pair is Inf*0; Inf if either operand is Inf; zero otherwise.
REQ-019 If the pair is special and FAST_SPECIAL==1, IDLE SHALL go directly to DONE; otherwise IDLE SHALL go to MULT.
REQ-020 MULT SHALL run a radix-2 shift-add on a 48-bit accumulator, processing one multiplier bit per cycle, with a 5-bit counter 0..23; it SHALL move to NORM when the counter reaches 23.
REQ-021 In NORM, if product[47]==1: mantissa=product[47:24], guard=product[23], sticky=|product[22:0], and exp=ea+eb-127+1.
REQ-022 In NORM, if product[47]==0: mantissa=product[46:23], guard=product[22], sticky=|product[21:0], and exp=ea+eb-127.
REQ-023 Exponent arithmetic SHALL be 10-bit signed, with no saturation; overflow and underflow detection belong downstream.
REQ-024 In NORM, the block SHALL move to DONE.
REQ-025 In DONE, out_valid SHALL be 1, and outputs SHALL hold stable while out_ready==0.
REQ-026 On out_ready==1 in DONE, the block SHALL return to IDLE; a new operand pair SHALL NOT be accepted in that same cycle.
REQ-027 Latency on the normal path SHALL be 26 cycles from the accept edge to the edge at which out_valid rises; on the fast special path it SHALL be 1 cycle.
REQ-028 Special results SHALL drive mantissa=0, guard=0, sticky=0 and exp=0, with exactly one flag high.
REQ-029 in_valid SHALL be ignored outside IDLE, and operand changes SHALL be ignored after the accept edge.
REQ-030 Throughput SHALL be one result per 27 cycles or more.

Reset
REQ-031 While rst_n==0, the FSM SHALL be IDLE, and in_ready=1, out_valid=0, and all data outputs and flags =0, counter=0 and accumulator=0.
REQ-032 Reset asserted in any state, including mid-MULT, SHALL abort the operation with no partial output.
REQ-033 On deassertion, the first accept SHALL be possible on the next rising edge.

Structure
REQ-034 A shared package fp_pkg SHALL hold the state enum, BIAS=127, the field widths (EXP_W=8, MAN_W=24, PROD_W=48), and a special-class typedef.
REQ-035 Normalization plus guard/sticky extraction SHALL be one combinational sub-module, fp_norm_gs, reused by other FP units.
REQ-036 Outputs SHALL map directly onto the downstream rounding stage inputs: mantissa, sign, guard and sticky.

Verification
REQ-037 0x3F800000*0x3F800000 -> sign=0, exp=127, mantissa=0x800000, guard=0, sticky=0, with out_valid 26 cycles after the accept edge.
REQ-038 0x3FC00000*0x3FC00000 (1.5*1.5) -> exp=128, mantissa=0x900000, guard=0, sticky=0.
REQ-039 0x3F800001*0x3F800001 -> exp=127, mantissa=0x800002, guard=0, sticky=1.
REQ-040 0xBF800000*0x3F800000 with out_ready held at 0 for 5 cycles -> sign=1 and outputs stable throughout; in_ready=0 until the cycle after the out_ready handshake.
REQ-041 FAST_SPECIAL=1: 0x7F800000*0x00000000 -> is_nan=1 one cycle after accept; 0x00000000*0x40000000 -> is_zero=1 and sign=0.
REQ-042 rst_n pulsed low at MULT counter=10 -> out_valid never rises for that operation; in_ready=1 immediately; the next operation completes with a correct result.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision multiplier definitions: field widths, FSM state encoding,
// special-operand classification and the result bundle handed to the rounding stage.
package fp_pkg;

  localparam int BIAS     = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MAN_W    = 24;
  localparam int PROD_W   = 48;
  localparam int OEXP_W   = 10;
  localparam int CNT_W    = 5;
  localparam int LAST_BIT = MAN_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    NORM,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_ZERO,
    SP_INF,
    SP_NAN
  } special_t;

  typedef struct packed {
    logic              sign;
    logic [OEXP_W-1:0] exp;
    logic [MAN_W-1:0]  mantissa;
    logic              guard;
    logic              sticky;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } result_t;

  // Denormals are flushed to zero, so a zero exponent field alone marks a zero operand.
  function automatic special_t classify(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    a_inf  = (a[30:23] == '1) && (a[22:0] == '0);
    b_inf  = (b[30:23] == '1) && (b[22:0] == '0);
    a_nan  = (a[30:23] == '1) && (a[22:0] != '0);
    b_nan  = (b[30:23] == '1) && (b[22:0] != '0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return SP_NAN;
    else if (a_inf || b_inf)                                        return SP_INF;
    else if (a_zero || b_zero)                                      return SP_ZERO;
    else                                                            return SP_NONE;
  endfunction

  function automatic result_t special_result(input logic sign, input special_t sp);
    result_t r;
    r         = '0;
    r.sign    = sign;
    r.is_zero = (sp == SP_ZERO);
    r.is_inf  = (sp == SP_INF);
    r.is_nan  = (sp == SP_NAN);
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_gs.sv
// Normalizes a 48-bit significand product to 24 bits and extracts guard/sticky.
// Purely combinational so other FP units can drop it into their own pipelines.
module fp_norm_gs
  import fp_pkg::*;
(
  input  logic [PROD_W-1:0] product,
  output logic [MAN_W-1:0]  mantissa,
  output logic              guard,
  output logic              sticky,
  output logic              norm_inc
);

  // A product of two [1,2) significands lies in [1,4): at most one bit of right shift.
  always_comb begin
    norm_inc = product[PROD_W-1];
    if (norm_inc) begin
      mantissa = product[PROD_W-1:PROD_W-MAN_W];
      guard    = product[PROD_W-MAN_W-1];
      sticky   = |product[PROD_W-MAN_W-2:0];
    end else begin
      mantissa = product[PROD_W-2:PROD_W-MAN_W-1];
      guard    = product[PROD_W-MAN_W-2];
      sticky   = |product[PROD_W-MAN_W-3:0];
    end
  end

endmodule

// File: rtl/fp_mult_core.sv
// Iterative single-precision multiply core: radix-2 shift-add over 24 cycles, then
// normalization; emits sign/exponent/mantissa/guard/sticky for a separate rounding stage.
module fp_mult_core
  import fp_pkg::*;
#(
  parameter int FAST_SPECIAL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [OEXP_W-1:0] exp,
  output logic [MAN_W-1:0]  mantissa,
  output logic              guard,
  output logic              sticky,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PROD_W-1:0]  acc_q;
  logic [PROD_W-1:0]  mcand_q;
  logic [MAN_W-1:0]   mplier_q;
  logic [EXP_W-1:0]   ea_q, eb_q;
  special_t           sp_q;
  result_t            res_q;

  special_t           in_sp;
  logic               accept;
  logic               take_fast;
  logic [MAN_W-1:0]   norm_man;
  logic               norm_guard, norm_sticky, norm_inc;
  logic [OEXP_W-1:0]  norm_exp;

  assign in_sp     = classify(a, b);
  assign accept    = (state_q == IDLE) && in_valid;
  assign take_fast = (FAST_SPECIAL != 0) && (in_sp != SP_NONE);

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = take_fast ? DONE : MULT;
      MULT: if (cnt_q == CNT_W'(LAST_BIT)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  fp_norm_gs u_norm (
    .product  (acc_q),
    .mantissa (norm_man),
    .guard    (norm_guard),
    .sticky   (norm_sticky),
    .norm_inc (norm_inc)
  );

  // Ten-bit two's-complement exponent; wrap is intentional, range checks live downstream.
  assign norm_exp = {2'b00, ea_q} + {2'b00, eb_q} - OEXP_W'(BIAS) + {{(OEXP_W-1){1'b0}}, norm_inc};

  // NOTE: the whole datapath is reset, not just control, so an abort mid-multiply
  // leaves no partial product or stale result visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      sp_q     <= SP_NONE;
      res_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ea_q     <= a[30:23];
            eb_q     <= b[30:23];
            mcand_q  <= {{(PROD_W-MAN_W){1'b0}}, |a[30:23], a[22:0]};
            mplier_q <= {|b[30:23], b[22:0]};
            acc_q    <= '0;
            cnt_q    <= '0;
            sp_q     <= in_sp;
            if (take_fast) begin
              res_q <= special_result(a[31] ^ b[31], in_sp);
            end else begin
              res_q      <= '0;
              res_q.sign <= a[31] ^ b[31];
            end
          end
        end
        MULT: begin
          // One multiplier bit per cycle, LSB first, multiplicand walking left.
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q != CNT_W'(LAST_BIT)) cnt_q <= cnt_q + CNT_W'(1);
        end
        NORM: begin
          if (sp_q != SP_NONE) begin
            res_q <= special_result(res_q.sign, sp_q);
          end else begin
            res_q <= '{sign:     res_q.sign,
                       exp:      norm_exp,
                       mantissa: norm_man,
                       guard:    norm_guard,
                       sticky:   norm_sticky,
                       is_zero:  1'b0,
                       is_inf:   1'b0,
                       is_nan:   1'b0};
          end
        end
        DONE: ; // result held until the rounding stage takes it
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sign      = res_q.sign;
  assign exp       = res_q.exp;
  assign mantissa  = res_q.mantissa;
  assign guard     = res_q.guard;
  assign sticky    = res_q.sticky;
  assign is_zero   = res_q.is_zero;
  assign is_inf    = res_q.is_inf;
  assign is_nan    = res_q.is_nan;

endmodule

// File: tb/tb_fp_mult_core.sv
// Randomized self-checking bench for fp_mult_core against an arithmetic reference model,
// plus directed cases for exact results, output hold, special bypass and mid-multiply reset.
module tb_fp_mult_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        out_valid, out_ready;
  logic        sign;
  logic [9:0]  exp;
  logic [23:0] mantissa;
  logic        guard, sticky, is_zero, is_inf, is_nan;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] last_res;

  fp_mult_core #(.FAST_SPECIAL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .exp       (exp),
    .mantissa  (mantissa),
    .guard     (guard),
    .sticky    (sticky),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan)
  );

  always #5 clk = ~clk;

  wire [39:0] dut_vec = {sign, exp, mantissa, guard, sticky, is_zero, is_inf, is_nan};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: real-valued product of the two significands, normalized into [1,2).
  function automatic void model(input logic [31:0] oa, input logic [31:0] ob,
                                output logic [39:0] r, output bit special);
    logic [7:0]      ea, eb;
    logic [22:0]     fa, fb;
    logic            s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned p;
    int              e;
    logic [23:0]     man;
    logic            g, st;
    ea = oa[30:23]; eb = ob[30:23];
    fa = oa[22:0];  fb = ob[22:0];
    s  = oa[31] ^ ob[31];
    a_zero = (ea == 0);   b_zero = (eb == 0);
    a_inf  = (ea == 255) && (fa == 0);
    b_inf  = (eb == 255) && (fb == 0);
    a_nan  = (ea == 255) && (fa != 0);
    b_nan  = (eb == 255) && (fb != 0);
    special = 1'b1;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      r = {s, 10'd0, 24'd0, 2'b00, 3'b001};
    else if (a_inf || b_inf)
      r = {s, 10'd0, 24'd0, 2'b00, 3'b010};
    else if (a_zero || b_zero)
      r = {s, 10'd0, 24'd0, 2'b00, 3'b100};
    else begin
      special = 1'b0;
      p = (longint'(fa) + 64'd8388608) * (longint'(fb) + 64'd8388608);
      e = int'(ea) + int'(eb) - 127;
      if (p >= 64'd140737488355328) begin   // 2^47: product >= 2.0
        man = 24'(p / 64'd16777216);
        g   = ((p / 64'd8388608) % 2) != 0;
        st  = (p % 64'd8388608) != 0;
        e   = e + 1;
      end else begin
        man = 24'(p / 64'd8388608);
        g   = ((p / 64'd4194304) % 2) != 0;
        st  = (p % 64'd4194304) != 0;
      end
      r = {s, 10'(e), man, g, st, 3'b000};
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic        s;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 15))
      0:       return {s, 8'd0, 23'd0};
      1:       return {s, 8'd0, f | 23'd1};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, f | 23'd1};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input int hold);
    logic [39:0] expv;
    bit          special;
    int          n, guard_cnt, lat_exp;
    model(oa, ob, expv, special);
    lat_exp = special ? 1 : 26;
    guard_cnt = 0;
    while (!in_ready && guard_cnt < 50) begin
      @(negedge clk);
      guard_cnt++;
    end
    check("idle_before_accept", in_ready, 1'b1);
    in_valid = 1'b1; a = oa; b = ob;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    check("in_ready_after_accept", in_ready, 1'b0);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 10) begin
        in_valid = 1'b1;   // must be ignored mid-operation
      end
    end
    in_valid = 1'b0;
    check("latency", n, lat_exp);
    check("sign", sign, expv[39]);
    check("exp", exp, expv[38:29]);
    check("mantissa", mantissa, expv[28:5]);
    check("guard_sticky", {guard, sticky}, expv[4:3]);
    check("flags", {is_zero, is_inf, is_nan}, expv[2:0]);
    last_res = dut_vec;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      check("hold_result", dut_vec, expv);
      check("hold_valid_ready", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;   // offered during the handshake cycle, must not be taken
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_handshake", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int vcount;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_ready_valid", {in_ready, out_valid}, 2'b10);
    check("reset_outputs", dut_vec, 40'd0);
    rst_n = 1'b1;

    // Accept on the very first edge after reset release.
    run_op(32'h3F800000, 32'h3F800000, 0);
    check("one_exp", last_res[38:29], 10'd127);
    check("one_man", last_res[28:5], 24'h800000);
    run_op(32'h3FC00000, 32'h3FC00000, 1);
    check("onehalf_exp_man", last_res[38:5], {10'd128, 24'h900000});
    run_op(32'h3F800001, 32'h3F800001, 0);
    check("ulp_man_gs", last_res[28:3], {24'h800002, 2'b01});
    run_op(32'hBF800000, 32'h3F800000, 5);
    check("neg_sign", last_res[39], 1'b1);
    run_op(32'h7F800000, 32'h00000000, 2);
    check("inf_times_zero_nan", last_res[2:0], 3'b001);
    run_op(32'h00000000, 32'h40000000, 0);
    check("zero_flag_sign", {last_res[39], last_res[2:0]}, 4'b0100);
    run_op(32'h00800000, 32'h00800000, 0);   // exponent goes negative
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 0);   // largest finite squared
    run_op(32'hFF800000, 32'h3F800000, 0);
    run_op(32'h7FC00000, 32'hFF800000, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(gen_operand(), gen_operand(), int'($urandom_range(0, 3)));
    end

    // Abort at MULT counter=10: ten MULT edges after the accept edge.
    in_valid = 1'b1; a = 32'h40490FDB; b = 32'h402DF854;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready_valid", {in_ready, out_valid}, 2'b10);
    check("abort_outputs", dut_vec, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("abort_no_output", vcount, 0);
    run_op(32'h40490FDB, 32'h402DF854, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
